uart_rx_frame_parser: RTL and testbench
=======================================

Name: uart_rx_frame_parser

Overview:
Sits directly downstream of Uart_Driver's receive side and consumes its o_user_rx_data / o_user_rx_valid byte stream in the user clock domain. Detects framed packets of the form HEAD0, HEAD1, LEN, LEN payload bytes, CHK. Buffers the payload and verifies the checksum. Releases a verified payload on a valid/ready stream with a last marker. Bad frames are discarded and flagged with an error pulse and code.

Parameters:
P_DATA_WIDTH, 8, byte width; fixed at 8, and other values are unsupported.
P_MAX_LEN, 16, maximum payload length in bytes; range 1..255.
P_HEAD0, 8'h55, first header byte.
P_HEAD1, 8'hAA, second header byte.
P_TIMEOUT_CYCLES, 100000, inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
clock  input  1  user clock, driven from Uart_Driver o_user_clk
reset  input  1  synchronous, active-high reset
i_user_rx_data  input  8  received byte
i_user_rx_valid  input  1  one-cycle strobe qualifying i_user_rx_data; no backpressure
o_payload_data  output  8  payload byte
o_payload_valid  output  1  payload byte valid
o_payload_last  output  1  marks the final payload byte of the frame
i_payload_ready  input  1  consumer accepts the byte when valid & ready
o_frame_ok  output  1  one-cycle pulse when a frame passes the checksum
o_err  output  1  one-cycle pulse when a frame is rejected
o_err_code  output  2  01 = bad length, 10 = checksum mismatch, 11 = timeout; holds its last value
o_drop  output  1  one-cycle pulse when an input byte is discarded during output
o_busy  output  1  high whenever the state is not S_IDLE

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on posedge clock.
- Reset values: all outputs are 0, the state is S_IDLE, and all counters and the checksum accumulator are 0.
- Reset mid-frame or mid-output abandons the frame immediately. No pulse is emitted.
- State S_IDLE:
  - A valid byte equal to P_HEAD0 moves the state to S_HEAD1.
  - Any other byte is ignored.
- State S_HEAD1:
  - A valid byte equal to P_HEAD1 moves the state to S_LEN.
  - A valid byte equal to P_HEAD0 keeps the state in S_HEAD1, so the parser resyncs.
  - Any other byte returns the state to S_IDLE silently.
- State S_LEN:
  - A LEN of 0 or greater than P_MAX_LEN pulses o_err with code 01 and returns to S_IDLE.
  - Otherwise LEN is latched, the accumulator is set to LEN, the write index is cleared, and the state moves to S_PAYLOAD.
- State S_PAYLOAD:
  - Each valid byte is written to buffer[wr_idx] and added to the accumulator (8-bit, modulo 256).
  - wr_idx increments on each byte.
  - After byte number LEN (wr_idx == LEN-1 on the write), the state moves to S_CHK.
- State S_CHK:
  - A valid byte equal to the accumulator pulses o_frame_ok in the same cycle as the transition, clears rd_idx, and moves the state to S_OUT.
  - A mismatch pulses o_err with code 10 and returns to S_IDLE.
- State S_OUT:
  - o_payload_valid = 1, o_payload_data = buffer[rd_idx], o_payload_last = (rd_idx == LEN-1).
  - A transfer occurs when valid & ready; rd_idx advances on each transfer.
  - The transfer with last = 1 returns the state to S_IDLE on the next edge, with valid low.
  - Data and last are held stable while ready is low.
  - Any i_user_rx_valid byte arriving in S_OUT is discarded and pulses o_drop.
- Latency: the first payload byte is valid one cycle after the CHK byte strobe. There is no minimum gap between frames beyond the return to S_IDLE.
- The buffer is P_MAX_LEN x 8 registers or distributed RAM. The index width is clog2(P_MAX_LEN+1).
- Simultaneous events: o_frame_ok and o_err are never high in the same cycle.

Optional Feature:
UART_FRAME_TIMEOUT_EN
- Defined:
  - In states S_HEAD1, S_LEN, S_PAYLOAD and S_CHK, a cycle counter clears on every i_user_rx_valid and on every state entry.
  - When the counter reaches P_TIMEOUT_CYCLES-1 with no byte arriving, o_err pulses with code 11 and the state returns to S_IDLE.
  - The counter is idle in S_IDLE and S_OUT.
- Undefined:
  - No counter logic exists, and a partial frame waits indefinitely.
  - Code 11 is never produced.

Test Plan:
1. Bytes 55 AA 03 11 22 33 69 -> o_frame_ok pulses once, then payload 11, 22, 33 with last only on 33; o_err stays 0.
2. Bytes 55 AA 03 11 22 33 6A -> o_err pulses with code 10; no o_payload_valid.
3. Bytes 55 AA 00 and 55 AA 11 (P_MAX_LEN=16) -> o_err pulses with code 01 each time; the parser then accepts the good frame 55 AA 01 7E 7F.
4. Bytes 55 55 AA 01 7E 7F -> resync; one payload byte 7E with last=1; o_frame_ok pulses.
5. Good 3-byte frame with i_payload_ready held low for 10 cycles, and two rx bytes injected during S_OUT -> data 11 held stable; o_drop pulses twice; all 3 bytes delivered after ready rises.
6. With UART_FRAME_TIMEOUT_EN and P_TIMEOUT_CYCLES=50: send 55 AA 02 11, then silence -> o_err with code 11 exactly 50 cycles after the 11 strobe; o_busy drops the next cycle. Reset asserted mid-payload in another run -> all outputs 0 and state S_IDLE.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// Frame parser for HEAD0 HEAD1 LEN payload CHK byte streams; replays verified payloads on a valid/ready port.
// Define UART_FRAME_TIMEOUT_EN to abandon partial frames after P_TIMEOUT_CYCLES idle cycles (error code 11).
//
// state     | meaning
// S_IDLE    | hunting for HEAD0
// S_HEAD1   | HEAD0 seen, expecting HEAD1 (HEAD0 again re-arms)
// S_LEN     | expecting the length byte
// S_PAYLOAD | buffering payload bytes and summing the checksum
// S_CHK     | expecting the checksum byte
// S_OUT     | replaying the buffered payload; incoming bytes are dropped
module uart_rx_frame_parser #(
  parameter int         P_DATA_WIDTH     = 8,
  parameter int         P_MAX_LEN        = 16,
  parameter logic [7:0] P_HEAD0          = 8'h55,
  parameter logic [7:0] P_HEAD1          = 8'hAA,
  parameter int         P_TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [P_DATA_WIDTH-1:0] i_user_rx_data,
  input  logic                    i_user_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_payload_data,
  output logic                    o_payload_valid,
  output logic                    o_payload_last,
  input  logic                    i_payload_ready,
  output logic                    o_frame_ok,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    o_drop,
  output logic                    o_busy
);

  localparam int IW = $clog2(P_MAX_LEN + 1);
  localparam int AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam logic [IW-1:0]           IDX_ONE   = IW'(1);
  localparam logic [P_DATA_WIDTH-1:0] MAX_LEN_B = P_DATA_WIDTH'(P_MAX_LEN);
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  if (P_DATA_WIDTH != 8 || P_MAX_LEN < 1 || P_MAX_LEN > 255 || P_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_rx_frame_parser: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD1,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t                  state, state_next;
  logic [IW-1:0]           len_q, wr_idx, rd_idx, len_last;
  logic [P_DATA_WIDTH-1:0] acc;
  logic [P_DATA_WIDTH-1:0] buffer [2**AW];
  logic [1:0]              err_code_q, err_code_new;
  logic                    err, frame_ok, tmo_hit;
  logic                    rx_v;
  logic [P_DATA_WIDTH-1:0] rx_d;

  assign rx_v     = i_user_rx_valid;
  assign rx_d     = i_user_rx_data;
  assign len_last = len_q - IDX_ONE;

  always_comb begin
    state_next   = state;
    frame_ok     = 1'b0;
    err          = 1'b0;
    err_code_new = err_code_q;
    case (state)
      S_IDLE: begin
        if (rx_v && rx_d == P_HEAD0) state_next = S_HEAD1;
      end
      S_HEAD1: begin
        if (rx_v) begin
          if (rx_d == P_HEAD1)      state_next = S_LEN;
          else if (rx_d == P_HEAD0) state_next = S_HEAD1;
          else                      state_next = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_v) begin
          if (rx_d == '0 || rx_d > MAX_LEN_B) begin
            err          = 1'b1;
            err_code_new = ERR_LEN;
            state_next   = S_IDLE;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_v && wr_idx == len_last) state_next = S_CHK;
      end
      S_CHK: begin
        if (rx_v) begin
          if (rx_d == acc) begin
            frame_ok   = 1'b1;
            state_next = S_OUT;
          end else begin
            err          = 1'b1;
            err_code_new = ERR_CHK;
            state_next   = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (i_payload_ready && rd_idx == len_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // tmo_hit only fires on a cycle without a byte, so it never collides with frame_ok
    if (tmo_hit) begin
      err          = 1'b1;
      err_code_new = ERR_TMO;
      state_next   = S_IDLE;
    end
    if (reset) begin
      frame_ok   = 1'b0;
      err        = 1'b0;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      acc        <= '0;
      err_code_q <= '0;
    end else begin
      state <= state_next;
      if (err) err_code_q <= err_code_new;
      case (state)
        S_LEN: begin
          if (state_next == S_PAYLOAD) begin
            len_q  <= rx_d[IW-1:0];
            acc    <= rx_d;
            wr_idx <= '0;
          end
        end
        S_PAYLOAD: begin
          if (rx_v) begin
            acc    <= acc + rx_d;
            wr_idx <= wr_idx + IDX_ONE;
          end
        end
        S_CHK: begin
          if (state_next == S_OUT) rd_idx <= '0;
        end
        S_OUT: begin
          if (i_payload_ready) rd_idx <= rd_idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; the read side is gated by o_payload_valid.
  always_ff @(posedge clock) begin
    if (state == S_PAYLOAD && rx_v) buffer[wr_idx[AW-1:0]] <= rx_d;
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(P_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_cnt;
  logic          timed, timed_next;

  assign timed      = (state == S_HEAD1) || (state == S_LEN) ||
                      (state == S_PAYLOAD) || (state == S_CHK);
  assign timed_next = (state_next == S_HEAD1) || (state_next == S_LEN) ||
                      (state_next == S_PAYLOAD) || (state_next == S_CHK);
  assign tmo_hit    = timed && !rx_v && tmo_cnt == '0;

  // Down-counter reloads on every byte and state entry; terminal count zero is the timeout.
  always_ff @(posedge clock) begin
    if (reset || !timed_next)                 tmo_cnt <= '0;
    else if (state_next != state || rx_v)     tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != '0)                   tmo_cnt <= tmo_cnt - TMO_ONE;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign o_payload_valid = (state == S_OUT) && !reset;
  assign o_payload_data  = o_payload_valid ? buffer[rd_idx[AW-1:0]] : '0;
  assign o_payload_last  = o_payload_valid && (rd_idx == len_last);
  assign o_frame_ok      = frame_ok;
  assign o_err           = err;
  assign o_err_code      = err ? err_code_new : err_code_q;
  assign o_drop          = (state == S_OUT) && rx_v && !reset;
  assign o_busy          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_frame_parser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] payload_data;
  logic       payload_valid, payload_last, frame_ok, err, drop, busy;
  logic [1:0] err_code;

  always #5 clock = ~clock;

  uart_rx_frame_parser #(
    .P_DATA_WIDTH    (8),
    .P_MAX_LEN       (16),
    .P_HEAD0         (8'h55),
    .P_HEAD1         (8'hAA),
    .P_TIMEOUT_CYCLES(50)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_user_rx_data (rx_data),
    .i_user_rx_valid(rx_valid),
    .o_payload_data (payload_data),
    .o_payload_valid(payload_valid),
    .o_payload_last (payload_last),
    .i_payload_ready(ready),
    .o_frame_ok     (frame_ok),
    .o_err          (err),
    .o_err_code     (err_code),
    .o_drop         (drop),
    .o_busy         (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] obs_data[$];
  logic       obs_last[$];
  logic [1:0] obs_err[$];
  int n_ok, n_drop, n_both, ok_cyc, err_cyc, first_valid_cyc, last_rx_cyc;
  logic busy_at_err;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (payload_valid && ready) begin
      obs_data.push_back(payload_data);
      obs_last.push_back(payload_last);
    end
    if (payload_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (frame_ok) begin n_ok++; ok_cyc = cyc; end
    if (err) begin obs_err.push_back(err_code); err_cyc = cyc; busy_at_err = busy; end
    if (drop) n_drop++;
    if (frame_ok && err) n_both++;
    if (rx_valid) last_rx_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_last.delete(); obs_err.delete();
    n_ok = 0; n_drop = 0; n_both = 0; ok_cyc = -1; err_cyc = -1;
    first_valid_cyc = -1; busy_at_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_q(input int gap_max);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic wait_payload(input int n, input int budget, input bit rnd_ready, input string tag);
    int k = 0;
    while (obs_data.size() < n && k < budget) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    ready = 1'b1;
    if (obs_data.size() < n) check_eq({tag, "_payload_wait_expired"}, obs_data.size(), n);
  endtask

  task automatic expect_good(input string tag, input int exp_drop);
    check_eq({tag, "_nbytes"}, obs_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
      check_eq({tag, "_data"}, obs_data[i], exp_q[i]);
      check_eq({tag, "_last"}, obs_last[i], (i == exp_q.size() - 1));
    end
    check_eq({tag, "_ok_count"}, n_ok, 1);
    check_eq({tag, "_err_count"}, obs_err.size(), 0);
    check_eq({tag, "_drops"}, n_drop, exp_drop);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check_eq({tag, "_err_count"}, obs_err.size(), 1);
    if (obs_err.size() > 0) check_eq({tag, "_err_code"}, obs_err[0], code);
    check_eq({tag, "_ok_count"}, n_ok, 0);
    check_eq({tag, "_nbytes"}, obs_data.size(), 0);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] b, sum, chk;
    int len, kind, k, mark;

    clear_obs();
    repeat (3) tick();
    check_eq("rst_valid", payload_valid, 1'b0);
    check_eq("rst_data", payload_data, 8'h00);
    check_eq("rst_err_code", err_code, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // basic good frame
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_q(0);
    wait_payload(3, 20, 1'b0, "t1");
    repeat (2) tick();
    expect_good("t1", 0);
    check_eq("t1_latency", first_valid_cyc - ok_cyc, 1);

    // checksum mismatch
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_q(0);
    repeat (4) tick();
    expect_err("t2", 2'b10);

    // bad lengths, then recovery
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h00};
    send_q(0);
    repeat (2) tick();
    expect_err("t3_len0", 2'b01);
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h11};
    send_q(0);
    repeat (2) tick();
    expect_err("t3_len17", 2'b01);
    check_eq("t3_code_held", err_code, 2'b01);
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    exp_q = '{8'h7E};
    send_q(0);
    wait_payload(1, 20, 1'b0, "t3");
    repeat (2) tick();
    expect_good("t3_good", 0);

    // resync on repeated HEAD0
    clear_obs();
    tx_q = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    send_q(0);
    wait_payload(1, 20, 1'b0, "t4");
    repeat (2) tick();
    expect_good("t4", 0);

    // backpressure with bytes arriving during output
    clear_obs();
    ready = 1'b0;
    tx_q = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_q(0);
    for (int i = 0; i < 10; i++) begin
      check_eq("t5_hold_valid", payload_valid, 1'b1);
      check_eq("t5_hold_data", payload_data, 8'h11);
      check_eq("t5_hold_last", payload_last, 1'b0);
      if (i == 2 || i == 5) send_byte(8'($urandom_range(0, 255)));
      else tick();
    end
    check_eq("t5_drop_count", n_drop, 2);
    ready = 1'b1;
    wait_payload(3, 20, 1'b0, "t5");
    repeat (2) tick();
    expect_good("t5", 2);

`ifdef UART_FRAME_TIMEOUT_EN
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h02, 8'h11};
    send_q(0);
    mark = last_rx_cyc;
    k = 0;
    while (obs_err.size() == 0 && k < 80) begin tick(); k++; end
    check_eq("t6_err_count", obs_err.size(), 1);
    if (obs_err.size() > 0) check_eq("t6_err_code", obs_err[0], 2'b11);
    check_eq("t6_err_delay", err_cyc - mark, 50);
    check_eq("t6_busy_at_err", busy_at_err, 1'b1);
    check_eq("t6_busy_next", busy, 1'b0);
`else
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h02, 8'h11};
    send_q(0);
    repeat (200) tick();
    check_eq("t6_no_timeout_err", obs_err.size(), 0);
    check_eq("t6_still_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_idle_after_reset", busy, 1'b0);
`endif

    // reset in the middle of a payload
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
    send_q(0);
    check_eq("t7_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    check_eq("t7_rst_valid", payload_valid, 1'b0);
    check_eq("t7_rst_last", payload_last, 1'b0);
    check_eq("t7_rst_data", payload_data, 8'h00);
    check_eq("t7_rst_ok", frame_ok, 1'b0);
    check_eq("t7_rst_err", err, 1'b0);
    check_eq("t7_rst_code", err_code, 2'b00);
    check_eq("t7_rst_drop", drop, 1'b0);
    check_eq("t7_rst_busy", busy, 1'b0);
    reset = 1'b0;
    check_eq("t7_no_pulses", obs_err.size() + n_ok, 0);
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    exp_q = '{8'h7E};
    send_q(0);
    wait_payload(1, 20, 1'b0, "t7");
    repeat (2) tick();
    expect_good("t7_after", 0);

    // randomized frames against the frame-level model
    for (int f = 0; f < 40; f++) begin
      clear_obs();
      tx_q.delete();
      exp_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h00;
        tx_q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) tx_q.push_back(8'h55);
      tx_q.push_back(8'h55);
      tx_q.push_back(8'hAA);
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        tx_q.push_back(8'(len));
        send_q(2);
        repeat (3) tick();
        expect_err("rnd_len", 2'b01);
      end else begin
        len = ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(1, 16);
        tx_q.push_back(8'(len));
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          tx_q.push_back(b);
          exp_q.push_back(b);
          sum = sum + b;
        end
        chk = sum;
        if (kind == 2) chk = chk ^ 8'($urandom_range(1, 255));
        tx_q.push_back(chk);
        send_q(2);
        if (kind == 2) begin
          repeat (3) tick();
          exp_q.delete();
          expect_err("rnd_chk", 2'b10);
        end else begin
          wait_payload(len, 400, 1'b1, "rnd");
          repeat (2) tick();
          expect_good("rnd", 0);
        end
      end
      check_eq("rnd_ok_err_exclusive", n_both, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
